// File: rtl/wb_dest_pipe.sv
// Destination-register tracker: decodes the write target, carries it E..W, flags RAW hazards.
// Latency: register-file write lands DEPTH clk edges after decode; hazard/stall/forward outputs are combinational from stage state.
// Backpressure: the pipe never freezes; stall/flush only replace the decode entry with a bubble. Optional feature: WA_FWD_EN.
module wb_dest_pipe #(
  parameter int          DEPTH   = 3,
  parameter logic [4:0]  RA_ADDR = 5'd31
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  instr_d,
  input  logic [1:0]                   wa_sel_d,
  input  logic                         is_load_d,
  input  logic                         stall,
  input  logic                         flush,
  output logic [4:0]                   wa_wb,
  output logic                         we_wb,
  output logic                         hazard_rs,
  output logic                         hazard_rt,
  output logic                         stall_req,
  output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
`ifdef WA_FWD_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rt_sel
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  logic [4:0]       rs_d, rt_d, rd_d;
  logic [4:0]       dest_d;
  logic             valid_d;
  logic             vld_0_next;
  logic [CW-1:0]    cnt_next;

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] ld_q;
  logic [4:0]       addr_q [DEPTH];

  assign rs_d = instr_d[25:21];
  assign rt_d = instr_d[20:16];
  assign rd_d = instr_d[15:11];

  // Opcode/function bits are irrelevant here; the W-stage load flag is carried but never consumed.
  logic unused_bits;
  assign unused_bits = ^{instr_d[31:26], instr_d[10:0], ld_q};

  // Destination select; "no write" maps to $0 so it is filtered by valid_d.
  always_comb begin
    dest_d = 5'd0;
    case (wa_sel_d)
      2'b00:   dest_d = rd_d;
      2'b01:   dest_d = rt_d;
      2'b10:   dest_d = RA_ADDR;
      default: dest_d = 5'd0;
    endcase
  end

  assign valid_d    = (wa_sel_d != 2'b11) && (dest_d != 5'd0);
  assign vld_0_next = valid_d && !(stall || flush);

  // Occupancy after the coming edge: new stage-0 entry plus stages 0..DEPTH-2 shifting down.
  always_comb begin
    cnt_next = CW'(vld_0_next);
    for (int k = 0; k < DEPTH-1; k++) begin
      cnt_next = cnt_next + CW'(vld_q[k]);
    end
  end

  // Stage shift register; stage 0 takes the decode entry or a bubble, later stages always advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q       <= '0;
      ld_q        <= '0;
      pending_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= 5'd0;
      end
    end else begin
      vld_q[0]    <= vld_0_next;
      ld_q[0]     <= vld_0_next && is_load_d;
      addr_q[0]   <= vld_0_next ? dest_d : 5'd0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k]  <= vld_q[k-1];
        ld_q[k]   <= ld_q[k-1];
        addr_q[k] <= addr_q[k-1];
      end
      pending_cnt <= cnt_next;
    end
  end

  assign wa_wb = addr_q[DEPTH-1];
  assign we_wb = vld_q[DEPTH-1];

  // RAW hazard against stages E..W-1; W writes in the first half-cycle so it is excluded.
  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    for (int k = 0; k < DEPTH-1; k++) begin
      if (vld_q[k] && (addr_q[k] == rs_d) && (rs_d != 5'd0)) hazard_rs = 1'b1;
      if (vld_q[k] && (addr_q[k] == rt_d) && (rt_d != 5'd0)) hazard_rt = 1'b1;
    end
  end

`ifdef WA_FWD_EN
  // Forward source select: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (vld_q[k] && (addr_q[k] == rs_d) && (rs_d != 5'd0)) fwd_rs_sel = CW'(k+1);
      if (vld_q[k] && (addr_q[k] == rt_d) && (rt_d != 5'd0)) fwd_rt_sel = CW'(k+1);
    end
  end

  // Only a load still in E cannot be forwarded yet; anything else is bypassed.
  assign stall_req = ld_q[0] && ((fwd_rs_sel == CW'(1)) || (fwd_rt_sel == CW'(1)));
`else
  // Without a bypass network every pending write to a source operand must be waited out.
  assign stall_req = hazard_rs || hazard_rt;
`endif

endmodule

// File: tb/tb_wb_dest_pipe.sv
module tb_wb_dest_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic [1:0]  wa_sel_d;
  logic        is_load_d;
  logic        stall;
  logic        flush;
  logic [4:0]  wa_wb;
  logic        we_wb;
  logic        hazard_rs;
  logic        hazard_rt;
  logic        stall_req;
  logic [1:0]  pending_cnt;
`ifdef WA_FWD_EN
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
`endif

  int checks   = 0;
  int failures = 0;

  wb_dest_pipe #(.DEPTH(3), .RA_ADDR(5'd31)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_d     (instr_d),
    .wa_sel_d    (wa_sel_d),
    .is_load_d   (is_load_d),
    .stall       (stall),
    .flush       (flush),
    .wa_wb       (wa_wb),
    .we_wb       (we_wb),
    .hazard_rs   (hazard_rs),
    .hazard_rt   (hazard_rt),
    .stall_req   (stall_req),
    .pending_cnt (pending_cnt)
`ifdef WA_FWD_EN
    ,
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h0, rs, rt, rd, 11'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; instr_d = '0; wa_sel_d = 2'b11; is_load_d = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    check("rst_we", we_wb, 0);
    check("rst_wa", wa_wb, 0);
    check("rst_cnt", pending_cnt, 0);
    check("rst_haz", {hazard_rs, hazard_rt, stall_req}, 0);
    tick(); tick();
    reset = 1'b0;

    // single rd write travels to W in three edges
    instr_d = mk(0, 0, 8); wa_sel_d = 2'b00;
    tick();
    instr_d = '0; wa_sel_d = 2'b11;
    check("t1_cnt_e1", pending_cnt, 1);
    check("t1_we_e1", we_wb, 0);
    tick();
    check("t1_cnt_e2", pending_cnt, 1);
    check("t1_we_e2", we_wb, 0);
    tick();
    check("t1_we_e3", we_wb, 1);
    check("t1_wa_e3", wa_wb, 8);
    check("t1_cnt_e3", pending_cnt, 1);
    tick();
    check("t1_we_e4", we_wb, 0);
    check("t1_cnt_e4", pending_cnt, 0);

    // link register, no-write and $0 destinations
    instr_d = mk(0, 0, 8); wa_sel_d = 2'b10;
    tick();
    wa_sel_d = 2'b11;
    tick(); tick();
    check("t2_ra_we", we_wb, 1);
    check("t2_ra_wa", wa_wb, 31);
    tick();
    check("t2_ra_done", we_wb, 0);
    instr_d = mk(0, 0, 8); wa_sel_d = 2'b11;
    tick();
    check("t2_nowr_cnt", pending_cnt, 0);
    instr_d = mk(0, 0, 0); wa_sel_d = 2'b00;
    tick();
    check("t2_rd0_cnt", pending_cnt, 0);
    instr_d = mk(0, 0, 5); wa_sel_d = 2'b01;
    tick();
    check("t2_rt0_cnt", pending_cnt, 0);
    wa_sel_d = 2'b11;
    tick(); tick();
    check("t2_zero_we", we_wb, 0);

    // RAW hazard on rs until the producer reaches W
    instr_d = mk(0, 9, 0); wa_sel_d = 2'b01;
    tick();
    instr_d = mk(9, 0, 0); wa_sel_d = 2'b11;
    #1;
    check("t3_hrs_e", hazard_rs, 1);
    check("t3_hrt_e", hazard_rt, 0);
`ifdef WA_FWD_EN
    check("t3_stall_fwd", stall_req, 0);
    check("t3_fwd_e", fwd_rs_sel, 1);
`else
    check("t3_stall", stall_req, 1);
`endif
    tick();
    check("t3_hrs_m", hazard_rs, 1);
    tick();
    check("t3_hrs_w", hazard_rs, 0);
    check("t3_we_w", we_wb, 1);
    check("t3_wa_w", wa_wb, 9);
`ifndef WA_FWD_EN
    check("t3_stall_w", stall_req, 0);
`endif
    instr_d = '0;
    tick();

    // stall bubbles stage 0 while older entry keeps moving
    instr_d = mk(0, 0, 10); wa_sel_d = 2'b00;
    tick();
    instr_d = mk(0, 0, 11); stall = 1'b1;
    tick();
    check("t4_stall_cnt", pending_cnt, 1);
    stall = 1'b0; wa_sel_d = 2'b11;
    tick();
    check("t4_adv_we", we_wb, 1);
    check("t4_adv_wa", wa_wb, 10);
    check("t4_adv_cnt", pending_cnt, 1);
    tick();
    check("t4_bub_we", we_wb, 0);
    check("t4_bub_cnt", pending_cnt, 0);
    instr_d = mk(0, 0, 12); wa_sel_d = 2'b00; stall = 1'b1; flush = 1'b1;
    tick();
    check("t4_sf_cnt", pending_cnt, 0);
    stall = 1'b0; instr_d = mk(0, 0, 13);
    tick();
    check("t4_fl_cnt", pending_cnt, 0);
    flush = 1'b0; wa_sel_d = 2'b11;
    tick(); tick();
    check("t4_fl_we", we_wb, 0);

    // asynchronous reset with three writes in flight
    wa_sel_d = 2'b00;
    instr_d = mk(0, 0, 1); tick();
    instr_d = mk(0, 0, 2); tick();
    instr_d = mk(0, 0, 3); tick();
    instr_d = mk(2, 3, 0); wa_sel_d = 2'b11;
    #1;
    check("t5_cnt3", pending_cnt, 3);
    check("t5_wa1", wa_wb, 1);
    check("t5_hrs", hazard_rs, 1);
    check("t5_hrt", hazard_rt, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_we", we_wb, 0);
    check("t5_rst_cnt", pending_cnt, 0);
    check("t5_rst_haz", {hazard_rs, hazard_rt}, 0);
    check("t5_rst_stall", stall_req, 0);
    reset = 1'b0;
    tick();
    check("t5_post_cnt", pending_cnt, 0);
    instr_d = '0;

`ifdef WA_FWD_EN
    // load-use stall then forward from stage 1
    instr_d = mk(0, 5, 0); wa_sel_d = 2'b01; is_load_d = 1'b1;
    tick();
    instr_d = mk(5, 0, 0); wa_sel_d = 2'b11; is_load_d = 1'b0;
    #1;
    check("t6_ld_stall", stall_req, 1);
    check("t6_ld_fwd0", fwd_rs_sel, 1);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("t6_ld_stall2", stall_req, 0);
    check("t6_ld_fwd1", fwd_rs_sel, 2);
    tick(); tick();
    instr_d = mk(0, 6, 0); wa_sel_d = 2'b01;
    tick();
    instr_d = mk(6, 0, 0); wa_sel_d = 2'b11;
    #1;
    check("t6_alu_fwd", fwd_rs_sel, 1);
    check("t6_alu_stall", stall_req, 0);
    tick(); tick(); tick();
    instr_d = mk(0, 0, 7); wa_sel_d = 2'b00;
    tick(); tick();
    instr_d = mk(0, 7, 0); wa_sel_d = 2'b11;
    #1;
    check("t6_young_rt", fwd_rt_sel, 1);
    check("t6_young_rs", fwd_rs_sel, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
